// File: rtl/cover_toggle_collector.sv
// Toggle-coverage receiver: sticky hit bitmap, distinct-hit counter and a valid/ready
// stream that reports each first-time hit once as a global cover index.
module cover_toggle_collector #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 28338,
  parameter int unsigned IDX_W       = 64,
  localparam int unsigned CW         = $clog2(WIDTH + 1),
  localparam int unsigned SW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_index,
  output logic [CW-1:0]    hit_count,
  output logic             all_hit
);

  // The owned range must fit inside the design-wide point space.
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
    $error("cover_toggle_collector: owned range exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit_q, hit_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d;
  logic             all_hit_q, all_hit_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [IDX_W-1:0] rpt_index_q, rpt_index_d;

  logic [WIDTH-1:0] new_hits;
  logic [CW-1:0]    new_count;
  logic [SW-1:0]    sel;
  logic             found;
  logic             load;

  always_comb begin
    new_hits  = (enable && !clear) ? (valid & ~hit_q) : '0;
    new_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_count = new_count + CW'(new_hits[i]);
    end
  end

  // Lowest pending index, taken from pending before this edge's capture.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel   = SW'(i);
        found = 1'b1;
      end
    end
  end

  assign load = !rpt_valid_q || rpt_ready;

  always_comb begin
    hit_d       = hit_q | new_hits;
    pending_d   = pending_q | new_hits;
    count_d     = count_q + new_count;
    all_hit_d   = (count_d == CW'(WIDTH));
    rpt_valid_d = rpt_valid_q;
    rpt_index_d = rpt_index_q;
    if (clear) begin
      // A transfer in this cycle still completes; no reload follows it.
      hit_d       = '0;
      pending_d   = '0;
      count_d     = '0;
      all_hit_d   = 1'b0;
      rpt_valid_d = 1'b0;
    end else if (load) begin
      rpt_valid_d = found;
      if (found) begin
        pending_d[sel] = 1'b0;
        rpt_index_d    = IDX_W'(COVER_INDEX) + IDX_W'(sel);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q       <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      all_hit_q   <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_index_q <= '0;
    end else begin
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      all_hit_q   <= all_hit_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_index_q <= rpt_index_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_index = rpt_index_q;
  assign hit_count = count_q;
  assign all_hit   = all_hit_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with WIDTH=9, COVER_INDEX=100.
module tb_cover_toggle_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  valid;
  logic        enable;
  logic        clear;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [63:0] rpt_index;
  logic [3:0]  hit_count;
  logic        all_hit;

  int tests = 0;
  int fails = 0;

  cover_toggle_collector #(
    .WIDTH       (9),
    .COVER_INDEX (100),
    .COVER_TOTAL (28338),
    .IDX_W       (64)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .enable    (enable),
    .clear     (clear),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_index (rpt_index),
    .hit_count (hit_count),
    .all_hit   (all_hit)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // T1: reset held with all points firing
    reset     = 1'b0;
    valid     = 9'h1FF;
    enable    = 1'b1;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("t1_rv_in_reset", 64'(rpt_valid), 64'd0);
    chk("t1_idx_in_reset", rpt_index, 64'd0);
    chk("t1_cnt_in_reset", 64'(hit_count), 64'd0);
    chk("t1_all_in_reset", 64'(all_hit), 64'd0);
    valid = 9'h000;
    reset = 1'b1;
    tick();
    tick();
    chk("t1_rv_after", 64'(rpt_valid), 64'd0);
    chk("t1_cnt_after", 64'(hit_count), 64'd0);
    chk("t1_all_after", 64'(all_hit), 64'd0);

    // T2: single hit, then repeat fire produces nothing
    rpt_ready = 1'b1;
    valid = 9'h010;
    tick();
    valid = 9'h000;
    chk("t2_cnt", 64'(hit_count), 64'd1);
    chk("t2_rv_capture_edge", 64'(rpt_valid), 64'd0);
    tick();
    chk("t2_rv", 64'(rpt_valid), 64'd1);
    chk("t2_idx", rpt_index, 64'd104);
    tick();
    chk("t2_rv_drained", 64'(rpt_valid), 64'd0);
    valid = 9'h010;
    tick();
    valid = 9'h000;
    tick();
    chk("t2_rv_refire", 64'(rpt_valid), 64'd0);
    chk("t2_cnt_refire", 64'(hit_count), 64'd1);

    // T3: full burst under backpressure, then back-to-back drain
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_cnt_cleared", 64'(hit_count), 64'd0);
    rpt_ready = 1'b0;
    valid = 9'h1FF;
    tick();
    valid = 9'h000;
    chk("t3_cnt", 64'(hit_count), 64'd9);
    chk("t3_all", 64'(all_hit), 64'd1);
    tick();
    chk("t3_rv_first", 64'(rpt_valid), 64'd1);
    chk("t3_idx_first", rpt_index, 64'd100);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_stall_rv", 64'(rpt_valid), 64'd1);
      chk("t3_stall_idx", rpt_index, 64'd100);
    end
    rpt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t3_drain_rv", 64'(rpt_valid), 64'd1);
      chk("t3_drain_idx", rpt_index, 64'(100 + k));
    end
    tick();
    chk("t3_rv_empty", 64'(rpt_valid), 64'd0);

    // T4: a lower index arriving during a stall does not pre-empt
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rpt_ready = 1'b0;
    valid = 9'h020;
    tick();
    valid = 9'h000;
    tick();
    chk("t4_idx_held", rpt_index, 64'd105);
    valid = 9'h001;
    tick();
    valid = 9'h000;
    chk("t4_idx_no_preempt", rpt_index, 64'd105);
    tick();
    chk("t4_idx_still", rpt_index, 64'd105);
    chk("t4_rv_still", 64'(rpt_valid), 64'd1);
    rpt_ready = 1'b1;
    tick();
    chk("t4_idx_second", rpt_index, 64'd100);
    chk("t4_rv_second", 64'(rpt_valid), 64'd1);
    tick();
    chk("t4_rv_empty", 64'(rpt_valid), 64'd0);

    // T5: clear beats a simultaneous fire and drops pending reports
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rpt_ready = 1'b0;
    valid = 9'h078;
    tick();
    valid = 9'h000;
    tick();
    chk("t5_idx_pre", rpt_index, 64'd103);
    chk("t5_cnt_pre", 64'(hit_count), 64'd4);
    clear = 1'b1;
    valid = 9'h002;
    tick();
    clear = 1'b0;
    valid = 9'h000;
    chk("t5_rv_clear", 64'(rpt_valid), 64'd0);
    chk("t5_cnt_clear", 64'(hit_count), 64'd0);
    tick();
    tick();
    chk("t5_rv_quiet", 64'(rpt_valid), 64'd0);
    chk("t5_cnt_quiet", 64'(hit_count), 64'd0);
    rpt_ready = 1'b1;
    valid = 9'h008;
    tick();
    valid = 9'h000;
    chk("t5_cnt_refire", 64'(hit_count), 64'd1);
    tick();
    chk("t5_rv_refire", 64'(rpt_valid), 64'd1);
    chk("t5_idx_refire", rpt_index, 64'd103);
    valid = 9'h002;
    tick();
    valid = 9'h000;
    chk("t5_bit1_new", 64'(hit_count), 64'd2);
    chk("t5_rv_gap", 64'(rpt_valid), 64'd0);
    tick();
    chk("t5_idx_bit1", rpt_index, 64'd101);
    tick();
    chk("t5_rv_empty", 64'(rpt_valid), 64'd0);

    // T6: enable=0 freezes capture; async reset drops an in-flight report
    enable = 1'b0;
    valid = 9'h0FF;
    tick();
    tick();
    valid = 9'h000;
    tick();
    chk("t6_cnt_frozen", 64'(hit_count), 64'd2);
    chk("t6_rv_frozen", 64'(rpt_valid), 64'd0);
    enable = 1'b1;
    rpt_ready = 1'b0;
    valid = 9'h001;
    tick();
    valid = 9'h000;
    tick();
    chk("t6_rv_stall", 64'(rpt_valid), 64'd1);
    chk("t6_idx_stall", rpt_index, 64'd100);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rv_async", 64'(rpt_valid), 64'd0);
    chk("t6_cnt_async", 64'(hit_count), 64'd0);
    chk("t6_idx_async", rpt_index, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rv_released", 64'(rpt_valid), 64'd0);
    chk("t6_all_released", 64'(all_hit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
